// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: command-driven burst generator around a Fibonacci LFSR.
// Each accepted command loads a seed and then streams LEN successive LFSR
// states over a valid/ready port. A normal finish is marked by a one-cycle
// done pulse, and an abort is marked by a one-cycle aborted pulse.
// Optional feature macro: LFSR_SIG_EN adds a MISR signature output sig that
// compacts every transferred beat.
module lfsr_burst_ctrl #(
   parameter int                 WIDTH        = 4,
   parameter logic [WIDTH-1:0]   TAP_MASK     = 4'b1100,
   parameter logic [WIDTH-1:0]   DEFAULT_SEED = 4'hF,
   parameter int                 LEN_W        = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [WIDTH-1:0]   cmd_seed,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy,
   output logic               done,
   output logic               aborted
`ifdef LFSR_SIG_EN
   ,
   output logic [WIDTH-1:0]   sig
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ABRT = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

   // One Fibonacci step: shift left and feed back the parity of the tapped bits.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ^(v & TAP_MASK)};
   endfunction

   state_t             state_r;
   state_t             state_next_s;
   logic [WIDTH-1:0]   q_r;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   cnt_r;
   logic               accept_s;
   logic               beat_s;
   logic               last_beat_s;

   // Outputs are decoded from the registered state only. cmd_ready is also
   // held low while reset is asserted.
   assign cmd_ready   = (state_r == IDLE) && !reset;
   assign out_valid   = (state_r == RUN);
   assign out_data    = q_r;
   assign busy        = (state_r != IDLE);
   assign done        = (state_r == DONE);
   assign aborted     = (state_r == ABRT);

   assign accept_s    = cmd_valid && cmd_ready;
   assign beat_s      = out_valid && out_ready;
   assign last_beat_s = (cnt_r == (len_r - LEN_ONE));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic. In RUN, abort takes priority over the final beat.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = (cmd_len != LEN_ZERO) ? RUN : DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_next_s = ABRT;
            end else if (beat_s && last_beat_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         ABRT:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // LFSR and beat counter. A load happens on command accept, and a step
   // happens on every transferred beat. A beat that coincides with abort still
   // counts as transferred.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r   <= DEFAULT_SEED;
         len_r <= LEN_ZERO;
         cnt_r <= LEN_ZERO;
      end else if (accept_s) begin
         q_r   <= (cmd_seed == Q_ZERO) ? DEFAULT_SEED : cmd_seed;
         len_r <= cmd_len;
         cnt_r <= LEN_ZERO;
      end else if (beat_s) begin
         q_r   <= lfsr_step(q_r);
         cnt_r <= cnt_r + LEN_ONE;
      end else begin
         q_r   <= q_r;
         cnt_r <= cnt_r;
      end
   end

`ifdef LFSR_SIG_EN
   logic [WIDTH-1:0] sig_r;
   assign sig = sig_r;

   // MISR signature. It clears on command accept and folds in each beat's
   // data, so it holds steady from done until the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         sig_r <= Q_ZERO;
      end else if (accept_s) begin
         sig_r <= Q_ZERO;
      end else if (beat_s) begin
         sig_r <= lfsr_step(sig_r) ^ out_data;
      end else begin
         sig_r <= sig_r;
      end
   end
`endif

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb_lfsr_burst_ctrl: directed bench for lfsr_burst_ctrl.
// Expected beats are pushed into a queue when a command is issued. A monitor
// pops them and compares them on every transferred beat.
module tb_lfsr_burst_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_seed;
   logic [7:0] cmd_len;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       busy;
   logic       done;
   logic       aborted;
`ifdef LFSR_SIG_EN
   logic [3:0] sig;
`endif

   int total = 0;
   int bad   = 0;
   int beats_seen = 0;
   logic [3:0] exp_q[$];

   // Maximal-length sequence for taps 1100, listed starting from F.
   logic [3:0] seq [0:14] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                              4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
   logic       stall_pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

   lfsr_burst_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_seed  (cmd_seed),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
`ifdef LFSR_SIG_EN
      ,
      .sig       (sig)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 15; i++) if (seq[i] == v) return i;
      return 0;
   endfunction

   logic       prev_stall = 1'b0;
   logic [3:0] prev_data  = 4'h0;

   // Beat monitor: scoreboard pop on each transfer, plus a hold check after a stall.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (prev_stall) chk("stall_hold", out_data, prev_data);
         if (out_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("beat_data", out_data, exp_q.pop_front());
            end
         end
         prev_stall = !out_ready;
         prev_data  = out_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Drive a command and push the first npush beats it should produce.
   task automatic issue(input logic [3:0] seed, input logic [7:0] len, input int npush);
      int k;
      k = idx_of((seed == 4'h0) ? 4'hF : seed);
      for (int i = 0; i < npush; i++) exp_q.push_back(seq[(k + i) % 15]);
      beats_seen = 0;
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_seed  = seed;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      cmd_seed  = 4'h3;
      cmd_len   = 8'd9;
   endtask

   // Wait, with a bound, for done. Optionally toggle out_ready, then check the return to IDLE.
   task automatic wait_done(input int exp_cycles, input bit stall, input int exp_beats);
      int i;
      i = 0;
      while (done !== 1'b1 && i < 200) begin
         if (stall) out_ready = stall_pat[i % 4];
         tick();
         i++;
      end
      out_ready = 1'b1;
      chk("done_seen", done, 1);
      chk("no_abort_pulse", aborted, 0);
      if (exp_cycles >= 0) chk("done_latency", i, exp_cycles);
      chk("beat_count", beats_seen, exp_beats);
      tick();
      chk("done_one_cycle", done, 0);
      chk("ready_after_done", cmd_ready, 1);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_seed = 4'h0; cmd_len = 8'd0;
      abort = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_q", out_data, 4'hF);
`ifdef LFSR_SIG_EN
      chk("rst_sig", sig, 4'h0);
`endif
      reset = 1'b0;
      tick();

      // 1: seed F, len 5, continuous ready
      issue(4'hF, 8'd5, 5);
      chk("lat_valid", out_valid, 1);
      chk("lat_seed", out_data, 4'hF);
      chk("run_ready_low", cmd_ready, 0);
      wait_done(5, 1'b0, 5);
`ifdef LFSR_SIG_EN
      chk("sig_burst1", sig, 4'h1);
`endif

      // 2: zero seed falls back to DEFAULT_SEED
      issue(4'h0, 8'd2, 2);
      chk("zero_seed_sub", out_data, 4'hF);
      wait_done(2, 1'b0, 2);

      // 3: stalled stream
      issue(4'hF, 8'd5, 5);
      wait_done(-1, 1'b1, 5);

      // 4: zero-length burst
      issue(4'h7, 8'd0, 0);
      chk("len0_done", done, 1);
      chk("len0_no_valid", out_valid, 0);
      chk("len0_busy", busy, 1);
      tick();
      chk("len0_ready", cmd_ready, 1);
      chk("len0_done_clr", done, 0);

      // 5: full period from seed 1, with wrap back to 1 on beat 16
      issue(4'h1, 8'd16, 16);
      wait_done(16, 1'b0, 16);

      // 6a: abort during the third beat; that beat still transfers
      issue(4'hF, 8'd5, 3);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abrt_pulse", aborted, 1);
      chk("abrt_no_done", done, 0);
      chk("abrt_no_valid", out_valid, 0);
      chk("abrt_ready_low", cmd_ready, 0);
      chk("abrt_q_advanced", out_data, 4'h8);
      chk("abrt_beats", beats_seen, 3);
      tick();
      chk("abrt_clr", aborted, 0);
      chk("abrt_ready_back", cmd_ready, 1);
      abort = 1'b1;
      tick();
      chk("abort_idle_ignored", busy, 0);
      abort = 1'b0;

      // 6b: reset mid-RUN drops the burst with no pulses
      issue(4'hF, 8'd5, 1);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_abrt", aborted, 0);
      chk("mid_rst_ready", cmd_ready, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_abrt", aborted, 0);
      chk("post_rst_ready", cmd_ready, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
